// File: rtl/tone_synth_pkg.sv
// ============================================================================
// Package : audio_pkg
// Shared types and constants for the tone synthesis stage.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned AMPLITUDE_DEF = 5_000_000;
  localparam int unsigned STEP          = AMPLITUDE_DEF / 16;

  localparam int HP_W  = 16;
  localparam int DUR_W = 20;
  localparam int VOL_W = 4;

endpackage

`default_nettype wire

// File: rtl/tone_synth_if.sv
// ============================================================================
// Interface : tone_synth_if
// Note request valid/ready channel from the sequencer.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface tone_synth_if;
  import audio_pkg::*;

  logic             note_valid;
  logic             note_ready;
  logic [HP_W-1:0]  note_half_period;
  logic [DUR_W-1:0] note_duration;
  logic [VOL_W-1:0] note_volume;

  modport master (
    output note_valid, note_half_period, note_duration, note_volume,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_half_period, note_duration, note_volume,
    output note_ready
  );
endinterface

`default_nettype wire

// File: rtl/tone_synth_envelope.sv
// ============================================================================
// Module : tone_envelope
// Linear envelope: one level step every ENV_RATE writes, up to target or down to 0.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tone_envelope
  import audio_pkg::*;
#(
  parameter int ENV_RATE = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr,
  input  logic             falling,
  input  logic [VOL_W-1:0] target,
  output logic [VOL_W-1:0] level,
  output logic             at_zero
);

  localparam int CW = (ENV_RATE > 1) ? $clog2(ENV_RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(ENV_RATE - 1);

  logic [CW-1:0] env_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_cnt <= '0;
      level   <= '0;
    end else if (clear) begin
      env_cnt <= '0;
      level   <= '0;
    end else if (wr) begin
      if (env_cnt == LAST) begin
        env_cnt <= '0;
        if (falling) begin
          if (level != '0) level <= level - 1'b1;
        end else if (level < target) begin
          level <= level + 1'b1;
        end
      end else begin
        env_cnt <= env_cnt + 1'b1;
      end
    end
  end

  assign at_zero = (level == '0);

endmodule

`default_nettype wire

// File: rtl/tone_synth.sv
// ============================================================================
// Module : tone_synth
// Streams an enveloped square wave per accepted note, one sample per FIFO write.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tone_synth
  import audio_pkg::*;
#(
  parameter int unsigned AMPLITUDE = AMPLITUDE_DEF,
  parameter int          ENV_RATE  = 480,
  parameter int          SAMPLE_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  tone_synth_if.slave         note,
  input  logic                stop,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                note_active,
  output logic                note_done
);

  localparam logic [SAMPLE_W-1:0] STEP_V = SAMPLE_W'(AMPLITUDE / 16);

  state_t             state, state_nxt;
  logic               wr, accept;
  logic [HP_W-1:0]    hp, half_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [VOL_W-1:0]   vol, level;
  logic               phase, at_zero;
  logic [SAMPLE_W-1:0] sample, mag, sample_nxt;

  assign wr              = audio_out_allowed;
  assign write_audio_out = audio_out_allowed;
  assign note.note_ready = (state == IDLE) && !stop && !reset;
  assign accept          = note.note_valid && note.note_ready;
  assign note_active     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    note_done = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = (note.note_duration == '0) ? RELEASE : PLAY;
      PLAY:    if (stop || (wr && dur_cnt == DUR_W'(1))) state_nxt = RELEASE;
      RELEASE: if (wr && at_zero) begin
                 state_nxt = IDLE;
                 note_done = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  tone_envelope #(.ENV_RATE(ENV_RATE)) u_env (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .wr      (wr && (state != IDLE)),
    .falling (state == RELEASE),
    .target  (vol),
    .level   (level),
    .at_zero (at_zero)
  );

  // Magnitude is formed unsigned, then negated for the low half-wave.
  assign mag        = STEP_V * SAMPLE_W'(level);
  assign sample_nxt = (hp == '0) ? '0 : (phase ? mag : (~mag + 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample   <= '0;
      hp       <= '0;
      vol      <= '0;
      phase    <= 1'b0;
      half_cnt <= '0;
      dur_cnt  <= '0;
    end else begin
      if (accept) begin
        hp       <= note.note_half_period;
        vol      <= note.note_volume;
        dur_cnt  <= note.note_duration;
        phase    <= 1'b1;
        half_cnt <= '0;
      end else if (wr && (state != IDLE)) begin
        if (hp != '0) begin
          if (half_cnt == hp - 1'b1) begin
            half_cnt <= '0;
            phase    <= ~phase;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        if (state == PLAY) dur_cnt <= dur_cnt - 1'b1;
      end
      if (wr) begin
        if (state == IDLE || (state == RELEASE && at_zero)) sample <= '0;
        else                                                 sample <= sample_nxt;
      end
    end
  end

  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;

endmodule

`default_nettype wire

// File: doc/tone_synth.md
Name: tone_synth

Overview:
Note-to-sample synthesis stage between the note sequencer and the Audio_Controller output FIFO. It accepts one note at a time (half-period in samples, duration in samples, volume) over a valid/ready handshake. It streams signed square-wave samples with a linear attack/release envelope, one sample per FIFO write. Write pacing follows audio_out_allowed, so one write equals one 48 kHz sample period. All timing therefore counts writes, not clk cycles.

Parameters:
AMPLITUDE, 5_000_000, peak sample magnitude at full level
ENV_RATE, 480, writes per envelope level step (must be ≥1)
SAMPLE_W, 32, sample width, two's complement

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
note_valid  in  1  note request valid
note_ready  out  1  block can accept a note
note_half_period  in  16  samples per half wave; 0 = silent note
note_duration  in  20  PLAY length in writes; 0 = empty note
note_volume  in  4  target envelope level 0..15
stop  in  1  abort current note (enter release)
audio_out_allowed  in  1  FIFO has space (from Audio_Controller)
write_audio_out  out  1  FIFO write strobe
left_channel_audio_out  out  SAMPLE_W  sample
right_channel_audio_out  out  SAMPLE_W  same as left
note_active  out  1  state != IDLE
note_done  out  1  one-cycle pulse on RELEASE→IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, sample register=0, level=0, all counters=0, phase=0. Outputs during reset: note_ready=0, note_active=0, note_done=0. write_audio_out=audio_out_allowed.
- Write strobe: write_audio_out = audio_out_allowed, combinational, in every state. The stream never starves. IDLE writes zeros.
- Sample outputs: left = right = sample register. The register updates only on write cycles ("wr").
- STEP = AMPLITUDE/16 (312500). Sample = +STEP·level when phase=1, −STEP·level when phase=0. Sample = 0 if the latched half_period is 0.
- note_ready = (state==IDLE) && !stop, combinational.
- Accept (note_valid && note_ready):
  - latch half_period, duration and volume;
  - set phase=1, half_cnt=0, env_cnt=0, level=0, dur_cnt=duration;
  - next state = PLAY, or RELEASE if duration==0.
- IDLE, on wr: sample ← 0.
- PLAY, on wr (all from current register values):
  - sample ← f(phase, level);
  - half_cnt: if half_cnt == half_period−1, then half_cnt←0 and phase toggles; else half_cnt+1 (held when half_period=0);
  - env_cnt wraps at ENV_RATE−1; on wrap, level+1 if level<volume;
  - dur_cnt−1; if dur_cnt==1, go to RELEASE.
- RELEASE, on wr:
  - waveform advances as in PLAY;
  - on env_cnt wrap, level−1 if level>0;
  - if level==0: sample←0, state→IDLE, note_done=1 for that cycle.
- stop in PLAY: RELEASE on the next clk, independent of wr. Counters and level are kept.
- stop in RELEASE or IDLE: no effect, except that note_ready is low while stop is high.
- note_valid while not ready: ignored. The upstream stage holds the request.
- Volume 0: the note runs for its full duration, outputs zero, then RELEASE exits on its first wr.
- audio_out_allowed low: all state frozen (except stop and accept).
- Arithmetic: STEP·level is at most 4,687,500. Compute it unsigned, then negate in SAMPLE_W.

Decomposition:
- Package audio_pkg holds:
  - state enum {IDLE, PLAY, RELEASE};
  - AMPLITUDE default and STEP localparam;
  - note request field widths (16/20/4).
- One sub-module: tone_envelope. It contains the env_cnt and level counter, with inputs wr, rising/falling mode, target and ENV_RATE, and outputs level and at_zero.
- The phase/half-period counter stays in tone_synth.

Test Plan:
- Bench setup for all scenarios: ENV_RATE=4, audio_out_allowed=1 unless stated.
- Basic tone: accept hp=50, dur=200, vol=15.
  - Phase toggles every 50 writes.
  - Level reaches 15 after 60 writes; the sample is then ±4,687,500.
  - RELEASE starts at write 200.
  - note_done pulses 60 writes later; note_ready is high the next cycle.
- Silent and empty notes:
  - hp=0, dur=10, vol=15: all samples 0; note_done after 10 writes plus release.
  - dur=0: immediate RELEASE, note_done on the first wr.
- Stop mid-note: hp=20, dur=1000, vol=8, stop pulsed at write 100.
  - RELEASE begins next clk from level 8.
  - IDLE after 32 writes.
  - stop held together with note_valid in IDLE → note not accepted.
- Backpressure: toggle audio_out_allowed 1-of-3 cycles.
  - Identical sample sequence to scenario 1 when compared per write.
  - No state change on non-write cycles.
- Async reset mid-PLAY:
  - Outputs return to 0 immediately with no clock needed.
  - note_active=0; note_ready=1 after reset deasserts; the next note starts at level 0.
